// File: rtl/cache_miss_sequencer.sv
// Miss handler between the cache RAM-side ports and a ready-handshaked main memory:
// stalls the core, writes back a dirty victim, refills the missed word, then releases.
module cache_miss_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic                   re_from_ram,
  input  logic                   we_to_ram,
  input  logic [DATA_WIDTH-1:0]  wd_to_ram,
  input  logic [ADDR_WIDTH-1:0]  w_addr_to_ram,
  output logic [DATA_WIDTH-1:0]  rd_from_ram,
  output logic                   stall,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic                   mem_ready,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic [COUNT_WIDTH-1:0] miss_count,
  output logic [COUNT_WIDTH-1:0] wb_count
);

  // state     | meaning
  // IDLE      | waiting for a miss; stall follows miss combinationally
  // WRITEBACK | writing the evicted dirty word to memory
  // REFILL    | reading the missed word from memory
  // DONE      | fill word presented to the cache for one cycle, stall released
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic                  miss;
  logic [ADDR_WIDTH-1:0] evict_addr;
  logic [DATA_WIDTH-1:0] evict_data;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic [DATA_WIDTH-1:0] fill_data;

  assign miss        = en & (re_from_ram | we_to_ram);
  assign rd_from_ram = fill_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      evict_addr <= '0;
      evict_data <= '0;
      miss_addr  <= '0;
      fill_data  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && miss) begin
        evict_addr <= {w_addr_to_ram[ADDR_WIDTH-1:2], 2'b00};
        evict_data <= wd_to_ram;
        miss_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
        if (miss_count != '1) miss_count <= miss_count + COUNT_WIDTH'(1);
      end
      if (state == WRITEBACK && mem_ready && wb_count != '1)
        wb_count <= wb_count + COUNT_WIDTH'(1);
      if (state == REFILL && mem_ready)
        fill_data <= mem_rdata;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        stall = miss;
        if (miss) state_next = we_to_ram ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = evict_addr;
        mem_wdata = evict_data;
        if (mem_ready) state_next = REFILL;
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = miss_addr;
        if (mem_ready) state_next = DONE;
      end
      // a miss still reported here is the access that was just serviced
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Directed bench for cache_miss_sequencer; inputs change and outputs are sampled
// around the falling edge, the DUT updates on the rising edge.
module tb_cache_miss_sequencer;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [AW-1:0] addr;
  logic          re_from_ram;
  logic          we_to_ram;
  logic [DW-1:0] wd_to_ram;
  logic [AW-1:0] w_addr_to_ram;
  logic [DW-1:0] rd_from_ram;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic [CW-1:0] miss_count;
  logic [CW-1:0] wb_count;

  int n_cmp = 0;
  int n_bad = 0;

  cache_miss_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .addr(addr),
    .re_from_ram(re_from_ram), .we_to_ram(we_to_ram),
    .wd_to_ram(wd_to_ram), .w_addr_to_ram(w_addr_to_ram),
    .rd_from_ram(rd_from_ram), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One miss: detect cycle in IDLE, w writeback cycles (if dirty), l refill cycles, DONE.
  // Leaves the bench in the DONE cycle with the core request already withdrawn.
  task automatic do_miss(input logic [AW-1:0] a, input logic [AW-1:0] exp_a, input bit dirty,
                         input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                         input int w, input int l, input logic [DW-1:0] rd);
    @(negedge clk);
    en = 1'b1; addr = a; re_from_ram = ~dirty; we_to_ram = dirty;
    w_addr_to_ram = ea; wd_to_ram = ed; mem_ready = 1'b0;
    #1;
    chk("detect_stall", stall, 1);
    chk("detect_req", mem_req, 0);
    if (dirty) begin
      for (int k = 1; k <= w; k++) begin
        @(negedge clk);
        mem_ready = (k == w);
        #1;
        chk("wb_stall", stall, 1);
        chk("wb_req", mem_req, 1);
        chk("wb_we", mem_we, 1);
        chk("wb_addr", mem_addr, ea);
        chk("wb_wdata", mem_wdata, ed);
      end
    end
    for (int k = 1; k <= l; k++) begin
      @(negedge clk);
      mem_ready = (k == l);
      mem_rdata = (k == l) ? rd : (32'hBAD0_0000 | k);
      #1;
      chk("rf_stall", stall, 1);
      chk("rf_req", mem_req, 1);
      chk("rf_we", mem_we, 0);
      chk("rf_addr", mem_addr, exp_a);
    end
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 32'h0;
    #1;
    chk("done_stall", stall, 0);
    chk("done_req", mem_req, 0);
    chk("done_addr", mem_addr, 0);
    chk("done_rd", rd_from_ram, rd);
    en = 1'b0; re_from_ram = 1'b0; we_to_ram = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; addr = '0; re_from_ram = 1'b0; we_to_ram = 1'b0;
    wd_to_ram = '0; w_addr_to_ram = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_rd", rd_from_ram, 0);
    chk("rst_miss_cnt", miss_count, 0);
    chk("rst_wb_cnt", wb_count, 0);
    rst = 1'b0;

    // clean miss, ready in third refill cycle
    do_miss(32'h0000_1004, 32'h0000_1004, 1'b0, 32'h0, 32'h0, 0, 3, 32'hDEAD_BEEF);
    @(negedge clk); #1;
    chk("t1_idle_stall", stall, 0);
    chk("t1_rd_hold", rd_from_ram, 32'hDEAD_BEEF);
    chk("t1_miss_cnt", miss_count, 1);
    chk("t1_wb_cnt", wb_count, 0);

    // dirty miss, zero wait states on both requests
    do_miss(32'h0000_1004, 32'h0000_1004, 1'b1, 32'h0000_0804, 32'h1234_5678, 1, 1, 32'h55AA_55AA);
    @(negedge clk); #1;
    chk("t2_miss_cnt", miss_count, 2);
    chk("t2_wb_cnt", wb_count, 1);

    // ready pulse with no request outstanding
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("t3_stall", stall, 0);
    chk("t3_req", mem_req, 0);
    chk("t3_we", mem_we, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("t3_stall_after", stall, 0);
    chk("t3_req_after", mem_req, 0);
    chk("t3_miss_cnt", miss_count, 2);
    chk("t3_wb_cnt", wb_count, 1);

    // reset while a writeback is waiting on memory
    @(negedge clk);
    en = 1'b1; we_to_ram = 1'b1; addr = 32'h0000_5000;
    w_addr_to_ram = 32'h0000_6000; wd_to_ram = 32'hFEED_FACE;
    @(negedge clk); #1;
    chk("t4_wb_req", mem_req, 1);
    chk("t4_wb_addr", mem_addr, 32'h0000_6000);
    @(negedge clk);
    rst = 1'b1; en = 1'b0; we_to_ram = 1'b0;
    @(negedge clk); #1;
    chk("t4_req", mem_req, 0);
    chk("t4_stall", stall, 0);
    chk("t4_miss_cnt", miss_count, 0);
    chk("t4_wb_cnt", wb_count, 0);
    chk("t4_rd", rd_from_ram, 0);
    rst = 1'b0;

    // back-to-back misses; unaligned core address gets word-aligned
    do_miss(32'h0000_2007, 32'h0000_2004, 1'b0, 32'h0, 32'h0, 0, 2, 32'hCAFE_F00D);
    do_miss(32'h0000_4008, 32'h0000_4008, 1'b1, 32'h0000_3000, 32'hA5A5_A5A5, 2, 1, 32'h0BAD_F00D);
    @(negedge clk); #1;
    chk("t5_miss_cnt", miss_count, 2);
    chk("t5_wb_cnt", wb_count, 1);

    // saturation of the 4-bit miss counter
    for (int i = 0; i < 16; i++) begin
      do_miss(32'h100 + 4 * i, 32'h100 + 4 * i, 1'b0, 32'h0, 32'h0, 0, 1, 32'h7700 + i);
      if (i == 12) begin
        @(negedge clk); #1;
        chk("t6_miss_cnt_15", miss_count, 15);
      end
    end
    @(negedge clk); #1;
    chk("t6_miss_cnt_sat", miss_count, 15);
    chk("t6_wb_cnt", wb_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
